// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the load/store memory responders.
package data_mem_responder_pkg;

  localparam int unsigned WORD_W = 32;

  // Responder FSM encoding, kept as plain constants for legacy compatibility.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Word index lies beyond the stored array.
  function automatic logic word_oob(input logic [31:0] addr, input int unsigned depth_words);
    return ({2'b00, addr[31:2]} >= depth_words);
  endfunction

  // A request errors when it is not word aligned or falls outside the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || word_oob(addr, depth_words);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// Word storage: one synchronous write port, two combinational read ports.
module mem_word_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata,
  input  logic [AW-1:0]     dbg_raddr,
  output logic [WORD_W-1:0] dbg_rdata
);

  // No reset: contents persist across responder reset.
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Commit a store on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata     = mem_q[raddr];
  assign dbg_rdata = mem_q[dbg_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder with valid/ready request and response channels.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_rdata
);

  localparam int unsigned      AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              mem_we;
  logic              access_err;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] dbg_mem_rdata;

  assign access_err = addr_err(addr_q, DEPTH_WORDS);

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk       (clk),
    .we        (mem_we),
    .waddr     (addr_q[AW+1:2]),
    .wdata     (wdata_q),
    .raddr     (addr_q[AW+1:2]),
    .rdata     (mem_rdata),
    .dbg_raddr (dbg_addr[AW+1:2]),
    .dbg_rdata (dbg_mem_rdata)
  );

  // Next-state, latency countdown, access and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          mem_we  = write_q && !access_err;
          rdata_d = (write_q || access_err) ? '0 : mem_rdata;
          err_d   = access_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers; memory array is not reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_rdata  = word_oob(dbg_addr, DEPTH_WORDS) ? '0 : dbg_mem_rdata;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-addressed data memory acting as the responder side of the CPU load/store interface.
- Accepts one request at a time over a valid/ready handshake and holds it for a parameterised access latency.
- Returns read data or a write acknowledgement over a valid/ready response channel.
- Replaces the zero-latency data memory so the next, multi-cycle processor can be exercised against realistic memory timing; a combinational debug port lets the bench inspect contents.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; word index = addr[31:2].
- LATENCY, 2, edges from request accept to response valid; legal range 1..15.
- CNT_W, 4, width of latency counter; must hold LATENCY-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept; high only in IDLE and not in reset.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; must be word aligned.
- req_wdata  input  32  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range request.
- dbg_addr  input  32  byte address for bench inspection.
- dbg_rdata  output  32  combinational mem[dbg_addr[31:2]]; 0 if out of range.

Behaviour:
- Reset (async, active-high):
  - State forced to IDLE; counter 0; captured request cleared.
  - resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0 while reset is high.
  - Memory array is NOT cleared; contents persist across reset.
- States:
  - IDLE: req_ready=1. On an edge with req_valid=1, capture req_write, req_addr and req_wdata; load counter=LATENCY-1; go BUSY.
  - BUSY: req_ready=0. Counter decrements each edge. On the edge where counter==0, perform the access:
    - Store: commit the write.
    - Load: latch mem word into resp_rdata.
    - Then go RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err held stable until resp_valid&&resp_ready at an edge, then go IDLE with resp_valid=0.
- Timing:
  - Request accepted at edge N gives resp_valid high after edge N+LATENCY.
  - Minimum turnaround with resp_ready tied high is LATENCY+2 edges per transaction; no pipelining and no overlap.
- Error rules:
  - req_addr[1:0]!=0, or word index >= DEPTH_WORDS, gives resp_err=1 and resp_rdata=0.
  - An erroring store does not modify memory. Error timing is identical to normal access (same latency).
- Captured-request stability: inputs changing after accept have no effect; only the captured copy is used.
- Ordering: transactions are strictly serialised, so a load issued after a store to the same address returns the stored data.
- dbg_rdata reflects committed writes immediately after the commit edge.
- Reset mid-operation:
  - Reset in BUSY before the commit edge: store is not committed and the response is dropped.
  - Reset in RESP: response is discarded.
- resp_ready high while not in RESP is ignored.
- req_valid low in IDLE: remain in IDLE with no state change.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - the 32-bit word-width constant.
  - the error-check rule (alignment plus range) as a named function or constant set for reuse by the instruction-memory responder.
- One sub-module is natural: mem_word_array (DEPTH_WORDS x 32 storage, one synchronous write port, two combinational read ports for the access path and the debug path).
- FSM, latency counter and error check stay in the top module.

Test Plan:
- LATENCY=2: store addr 0x10, data 0xDEADBEEF, resp_ready=1 -> resp_valid high after edge N+2, resp_err=0, resp_rdata=0; dbg_addr=0x10 reads 0xDEADBEEF.
- Load addr 0x10 right after that store -> resp_rdata=0xDEADBEEF after 2 edges; req_ready low from accept until response handshake completes.
- Store addr 0x13 (misaligned) with data 0x1 -> resp_err=1, resp_rdata=0; dbg word 0x10 still 0xDEADBEEF. Load addr 0x400 (index 256) -> resp_err=1.
- Backpressure: load completes while resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable throughout; new req_valid ignored (req_ready=0); response handshakes on the first edge with resp_ready=1.
- Reset mid-BUSY: store 0x55AA55AA to 0x20 accepted, reset pulsed before the commit edge -> outputs 0 during reset, dbg word 0x20 unchanged, req_ready=1 after reset release.
- LATENCY=1 build: four back-to-back loads with resp_ready=1 -> each response exactly 1 edge after accept; total 12 edges for 4 transactions.
